// File: rtl/piso_pkg.sv
// Shared types, width helpers and reset values for the PISO transmitter.
package piso_pkg;

  // Frame FSM: waiting for a word, or shifting one out.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Default geometry used when a parent does not override the parameters.
  localparam int DEF_WIDTH      = 4;
  localparam int DEF_BIT_CYCLES = 4;

  // Divider counter width: max(1, clog2(bit_cycles)).
  function automatic int div_w(input int bit_cycles);
    int w;
    w = $clog2(bit_cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // Bit counter width: wide enough to hold 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Widths for the default geometry.
  localparam int DIV_W = div_w(DEF_BIT_CYCLES);
  localparam int CNT_W = cnt_w(DEF_WIDTH);

  // Output values held while clr_n is asserted.
  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_TICK  = 1'b0;
  localparam logic   RST_BUSY  = 1'b0;
  localparam logic   RST_DONE  = 1'b0;
  localparam logic   RST_READY = 1'b1;

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake between a producer (master) and the PISO transmitter (slave).
interface piso_tx_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/piso_tick_gen.sv
// Bit-period divider: raises a registered one-cycle tick on the last clock
// of every BIT_CYCLES-long bit period while enabled.
module piso_tick_gen
  import piso_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic clr_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int                  DIV_BITS = div_w(BIT_CYCLES);
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(BIT_CYCLES - 1);
  localparam logic [DIV_BITS-1:0] DIV_ZERO = {DIV_BITS{1'b0}};

  logic [DIV_BITS-1:0] div_cnt_r;
  logic [DIV_BITS-1:0] div_nxt_s;
  logic                tick_r;

  // Next divider value: wrap to zero after the terminal count.
  always_comb begin
    div_nxt_s = DIV_ZERO;
    if (div_cnt_r == DIV_LAST) begin
      div_nxt_s = DIV_ZERO;
    end else begin
      div_nxt_s = div_cnt_r + DIV_BITS'(1);
    end
  end

  // Divider and tick registers; the tick is pre-computed from the next count
  // so it is high in exactly the cycle where the count sits at its terminal.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_cnt_r <= DIV_ZERO;
      tick_r    <= RST_TICK;
    end else if (restart) begin
      div_cnt_r <= DIV_ZERO;
      tick_r    <= (DIV_LAST == DIV_ZERO);
    end else if (enable) begin
      div_cnt_r <= div_nxt_s;
      tick_r    <= (div_nxt_s == DIV_LAST);
    end else begin
      div_cnt_r <= DIV_ZERO;
      tick_r    <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a word on a valid/ready handshake
// and shifts it out MSB-first, one bit every BIT_CYCLES clocks.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic         clk,
  input  logic         clr_n,
  piso_tx_if.slave     bus,
  output logic         so,
  output logic         bit_tick,
  output logic         busy,
  output logic         done
);

  localparam int                  CNT_BITS = cnt_w(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(WIDTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

  state_t              state_r;
  logic [WIDTH-1:0]    shreg_r;
  logic [CNT_BITS-1:0] bit_cnt_r;
  logic                busy_r;
  logic                done_r;
  logic                ready_r;

  logic accept_s;
  logic tick_s;
  logic last_tick_s;
  logic tick_en_s;

  // Handshake and end-of-frame decode; these only feed registers.
  always_comb begin
    accept_s    = (state_r == IDLE) && bus.din_valid;
    last_tick_s = (state_r == SHIFT) && tick_s && (bit_cnt_r == LAST_BIT);
    tick_en_s   = (state_r == SHIFT) && !last_tick_s;
  end

  piso_tick_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_tick_gen (
    .clk     (clk),
    .clr_n   (clr_n),
    .enable  (tick_en_s),
    .restart (accept_s),
    .tick    (tick_s)
  );

  // Frame FSM with shift register, bit counter and registered status flags.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r   <= RST_STATE;
      shreg_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= CNT_ZERO;
      busy_r    <= RST_BUSY;
      done_r    <= RST_DONE;
      ready_r   <= RST_READY;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.din_valid) begin
            shreg_r   <= bus.din;
            bit_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b1;
            ready_r   <= 1'b0;
            state_r   <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            // The final shift leaves the register all-zero, so so idles low.
            shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= CNT_ZERO;
              busy_r    <= 1'b0;
              ready_r   <= 1'b1;
              done_r    <= 1'b1;
              state_r   <= IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_BITS'(1);
            end
          end else begin
            shreg_r <= shreg_r;
          end
        end
        default: begin
          state_r   <= RST_STATE;
          shreg_r   <= {WIDTH{1'b0}};
          bit_cnt_r <= CNT_ZERO;
          busy_r    <= RST_BUSY;
          done_r    <= RST_DONE;
          ready_r   <= RST_READY;
        end
      endcase
    end
  end

  assign so            = shreg_r[WIDTH-1];
  assign bit_tick      = tick_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign bus.din_ready = ready_r;

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: a 4-bit/4-cycle instance and an
// 8-bit/1-cycle instance, a frame-level reference model, and directed tests.
module tb_piso_tx;

  localparam int W4 = 4;
  localparam int B4 = 4;
  localparam int N4 = W4 * B4;
  localparam int W8 = 8;
  localparam int B8 = 1;
  localparam int N8 = W8 * B8;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;

  always #5 clk = ~clk;

  piso_tx_if #(.WIDTH(W4)) bus4 ();
  piso_tx_if #(.WIDTH(W8)) bus8 ();

  logic so4, tick4, busy4, done4;
  logic so8, tick8, busy8, done8;

  piso_tx #(.WIDTH(W4), .BIT_CYCLES(B4)) u_dut4 (
    .clk      (clk),
    .clr_n    (clr_n),
    .bus      (bus4.slave),
    .so       (so4),
    .bit_tick (tick4),
    .busy     (busy4),
    .done     (done4)
  );

  piso_tx #(.WIDTH(W8), .BIT_CYCLES(B8)) u_dut8 (
    .clk      (clk),
    .clr_n    (clr_n),
    .bus      (bus8.slave),
    .so       (so8),
    .bit_tick (tick8),
    .busy     (busy8),
    .done     (done8)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: mc is the cycle index within a frame (0 = idle,
  // 1..N = bit cycles, N+1 = done cycle, during which a new word may be taken).
  int         mc4 = 0;
  int         mc8 = 0;
  logic [7:0] word4 = 8'h00;
  logic [7:0] word8 = 8'h00;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mc4 <= 0;
      mc8 <= 0;
    end else begin
      if ((mc4 == 0 || mc4 == N4 + 1) && bus4.din_valid) begin
        word4 <= {4'b0000, bus4.din};
        mc4   <= 1;
      end else if (mc4 >= 1 && mc4 <= N4) begin
        mc4 <= mc4 + 1;
      end else begin
        mc4 <= 0;
      end
      if ((mc8 == 0 || mc8 == N8 + 1) && bus8.din_valid) begin
        word8 <= bus8.din;
        mc8   <= 1;
      end else if (mc8 >= 1 && mc8 <= N8) begin
        mc8 <= mc8 + 1;
      end else begin
        mc8 <= 0;
      end
    end
  end

  // Expected {din_ready, done, busy, bit_tick, so} for frame cycle c.
  function automatic logic [4:0] expect_out(input int c, input int n, input int bc,
                                            input int w, input logic [7:0] word);
    logic t;
    logic s;
    if (c == 0) return 5'b10000;
    if (c == n + 1) return 5'b11000;
    s = word[w - 1 - (c - 1) / bc];
    t = ((c % bc) == 0);
    return {1'b0, 1'b0, 1'b1, t, s};
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkv("dut4_outputs", 32'({bus4.din_ready, done4, busy4, tick4, so4}),
           32'(expect_out(mc4, N4, B4, W4, word4)));
    checkv("dut8_outputs", 32'({bus8.din_ready, done8, busy8, tick8, so8}),
           32'(expect_out(mc8, N8, B8, W8, word8)));
  end

  // Downstream shift-left samplers clocked-enabled by bit_tick.
  logic [3:0] samp4 = 4'h0;
  logic [7:0] samp8 = 8'h00;
  always @(posedge clk) begin
    if (tick4) samp4 <= {samp4[2:0], so4};
    if (tick8) samp8 <= {samp8[6:0], so8};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send4(input logic [3:0] w);
    bus4.din       = w;
    bus4.din_valid = 1'b1;
    @(posedge clk);
    #2;
    bus4.din_valid = 1'b0;
  endtask

  logic [15:0] so_tab;
  logic [15:0] tick_tab;
  logic [7:0]  a5;
  int          busy_cnt, done_cnt, so_hi;
  logic [3:0]  edge_w;

  initial begin
    bus4.din = 4'h0; bus4.din_valid = 1'b0;
    bus8.din = 8'h00; bus8.din_valid = 1'b0;

    // Power-on reset, checked before any clock edge.
    #1 clr_n = 1'b0;
    #1;
    checkv("por_outs4", 32'({so4, tick4, busy4, done4, bus4.din_ready}), 32'(5'b00001));
    checkv("por_outs8", 32'({so8, tick8, busy8, done8, bus8.din_ready}), 32'(5'b00001));
    step(2);
    clr_n = 1'b1;
    step(2);

    // Single word 1011.
    so_tab   = 16'b1111_0000_1111_1111;
    tick_tab = 16'b0001_0001_0001_0001;
    send4(4'b1011);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c <= 16) begin
        checkv("t2_so", 32'(so4), 32'(so_tab[16 - c]));
        checkv("t2_tick", 32'(tick4), 32'(tick_tab[16 - c]));
        checkv("t2_done_low", 32'(done4), 32'(1'b0));
      end else begin
        checkv("t2_done_c17", 32'(done4), 32'(1'b1));
        checkv("t2_ready_c17", 32'(bus4.din_ready), 32'(1'b1));
        checkv("t2_sampler", 32'(samp4), 32'(4'b1011));
      end
    end
    step(1);

    // Back-to-back with valid held and din toggling while busy.
    bus4.din = 4'b1011; bus4.din_valid = 1'b1;
    @(posedge clk);
    #2;
    bus4.din = 4'b0110;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 5)  bus4.din = 4'b1001;
      if (c == 10) bus4.din = 4'b0000;
      if (c == 14) bus4.din = 4'b0110;
      if (c == 16) checkv("t3_ready_c16", 32'(bus4.din_ready), 32'(1'b0));
      if (c == 17) begin
        checkv("t3_done1", 32'(done4), 32'(1'b1));
        checkv("t3_ready_c17", 32'(bus4.din_ready), 32'(1'b1));
        checkv("t3_sampler1", 32'(samp4), 32'(4'b1011));
      end
      if (c == 18) begin
        bus4.din_valid = 1'b0;
        checkv("t3_busy2", 32'(busy4), 32'(1'b1));
        checkv("t3_so2_first", 32'(so4), 32'(1'b0));
      end
      if (c == 22) checkv("t3_so2_second", 32'(so4), 32'(1'b1));
      if (c == 34) begin
        checkv("t3_done2", 32'(done4), 32'(1'b1));
        checkv("t3_sampler2", 32'(samp4), 32'(4'b0110));
      end
    end
    step(1);

    // Reset in cycle 6 of a 1111 frame.
    send4(4'b1111);
    repeat (5) @(posedge clk);
    #2;
    checkv("t4_busy_before", 32'(busy4), 32'(1'b1));
    #1 clr_n = 1'b0;
    #1;
    checkv("t4_rst_outs", 32'({so4, tick4, busy4, done4, bus4.din_ready}), 32'(5'b00001));
    repeat (2) @(posedge clk);
    #3 clr_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkv("t4_no_done", 32'(done4), 32'(1'b0));
    end
    step(1);
    send4(4'b0001);
    repeat (17) @(negedge clk);
    checkv("t4_done_after", 32'(done4), 32'(1'b1));
    checkv("t4_sampler", 32'(samp4), 32'(4'b0001));
    step(1);

    // BIT_CYCLES=1 instance, word A5.
    a5 = 8'hA5;
    bus8.din = 8'hA5; bus8.din_valid = 1'b1;
    @(posedge clk);
    #2;
    bus8.din_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        checkv("t5_so", 32'(so8), 32'(a5[8 - c]));
        checkv("t5_tick", 32'(tick8), 32'(1'b1));
        checkv("t5_ready_low", 32'(bus8.din_ready), 32'(1'b0));
      end else begin
        checkv("t5_done_c9", 32'(done8), 32'(1'b1));
        checkv("t5_ready_c9", 32'(bus8.din_ready), 32'(1'b1));
        checkv("t5_tick_c9", 32'(tick8), 32'(1'b0));
        checkv("t5_sampler", 32'(samp8), 32'(8'hA5));
      end
    end
    step(1);

    // Edge words 0000 and 1111.
    for (int k = 0; k < 2; k++) begin
      edge_w = (k == 0) ? 4'b0000 : 4'b1111;
      busy_cnt = 0; done_cnt = 0; so_hi = 0;
      send4(edge_w);
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (busy4) busy_cnt++;
        if (done4) done_cnt++;
        if (so4) so_hi++;
      end
      checkv("t6_busy_cycles", 32'(busy_cnt), 32'(16));
      checkv("t6_done_count", 32'(done_cnt), 32'(1));
      checkv("t6_so_high_cycles", 32'(so_hi), (k == 0) ? 32'(0) : 32'(16));
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: the stage directly upstream of the team's SIPO capture register.
- Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out MSB-first on so.
- Each bit is held for BIT_CYCLES clocks, with a one-cycle bit_tick strobe marking the sample point.
- A downstream shift-left SIPO clocked/enabled by bit_tick therefore reassembles the original word unchanged.

Parameters:
- WIDTH, 4: word width in bits; legal range >= 2.
- BIT_CYCLES, 4: clock cycles per serial bit; legal range >= 1. Real hardware uses a large value (e.g. 2^24); benches use small values.

Ports:
- clk  input  1  system clock, rising-edge.
- clr_n  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  parallel word; sampled only on handshake.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  transmitter can accept a word (high only in IDLE).
- so  output  1  serial data, MSB first; 0 when idle.
- bit_tick  output  1  one-cycle strobe on the last cycle of each bit period; downstream samples so on this.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the final bit period of a frame.

Behaviour:
- Reset (clr_n=0, asynchronous, immediate):
  - FSM to IDLE; shift register, divider and bit counters cleared.
  - so=0, bit_tick=0, busy=0, done=0, din_ready=1.
- FSM states: IDLE, SHIFT.
- IDLE: din_ready=1, so=0, busy=0.
  - On a rising edge with din_valid=1: load shreg<=din; clear div_cnt and bit_cnt; go to SHIFT.
- SHIFT: busy=1, din_ready=0, so=shreg[WIDTH-1].
  - div_cnt counts 0..BIT_CYCLES-1; bit_tick=1 (registered) in the cycle where div_cnt==BIT_CYCLES-1.
  - At the edge ending a tick cycle: shreg shifts left by one (LSB fill 0), bit_cnt increments, div_cnt wraps to 0.
  - At the edge ending the tick of bit WIDTH-1: go to IDLE; done=1 for exactly the following cycle, which is also the first IDLE cycle with din_ready=1.
- Latency and throughput:
  - Accept at edge E0 → bit k occupies cycles k*BIT_CYCLES+1 .. (k+1)*BIT_CYCLES.
  - done is high in cycle WIDTH*BIT_CYCLES+1.
  - Minimum frame-to-frame spacing is WIDTH*BIT_CYCLES+1 cycles (one idle cycle between frames).
- din_valid while busy: ignored; din is not sampled and no state changes. The producer must hold din_valid until it sees din_ready.
- BIT_CYCLES=1: bit_tick is high in every SHIFT cycle; one bit per clock.
- Reset mid-frame: the partial frame is discarded, done is not pulsed, and the next handshake after reset release starts a clean frame.
- Counter widths:
  - div_cnt = max(1, clog2(BIT_CYCLES)).
  - bit_cnt = clog2(WIDTH+1).
  - No wrap beyond the terminal values.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational paths.

Decomposition:
- Shared package piso_pkg holds:
  - state enum {IDLE, SHIFT};
  - width helper constants (DIV_W, CNT_W) derived from the parameters;
  - reset-value localparams.
- One sub-module, piso_tick_gen: parameterised BIT_CYCLES divider.
  - Inputs: clk, clr_n, enable (=SHIFT), restart (=handshake).
  - Output: registered tick on the terminal count.
- FSM, shift register, bit counter and done logic stay in piso_tx.

Test Plan:
1. Reset: assert clr_n=0 mid-simulation, any stimulus → so=0, busy=0, bit_tick=0, done=0, din_ready=1 without waiting for a clock edge.
2. Single word, WIDTH=4, BIT_CYCLES=4, din=4'b1011:
   - so = 1,0,1,1, each held 4 cycles;
   - bit_tick high in cycles 4, 8, 12, 16; done high in cycle 17;
   - a shift-left sampler enabled by bit_tick captures 4'b1011.
3. Back-to-back: din_valid held high, din=4'b1011 then 4'b0110 presented while busy (din toggled during the frame) → second word accepted only in cycle 17 and serialises as 0,1,1,0; sampler reads 4'b1011 then 4'b0110.
4. Reset mid-frame: assert clr_n=0 in cycle 6 of a 4'b1111 frame → outputs go to reset values immediately and no done pulse. After release, 4'b0001 transmits correctly and the sampler reads 4'b0001.
5. BIT_CYCLES=1, WIDTH=8, din=8'hA5:
   - so = 1,0,1,0,0,1,0,1 in cycles 1–8;
   - bit_tick high for 8 consecutive cycles; done in cycle 9; din_ready high in cycle 9.
6. Edge words 4'b0000 and 4'b1111 (BIT_CYCLES=4) → busy high for exactly 16 cycles each, so constant across the frame, and exactly one done per frame.
